// File: rtl/uci_line_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// uci_line_arbiter_pkg
//   Shared definitions for the UCI output-line arbiter.
//   - NEWLINE     : line terminator byte; a line ends when it is transferred
//   - arb_state_t : arbiter state, IDLE (arbitrating) or LOCKED (line owned)
// ---------------------------------------------------------------------------
package uci_line_arbiter_pkg;

    localparam logic [7:0] NEWLINE = 8'h0A;

    typedef enum logic {
        ARB_IDLE,
        ARB_LOCKED
    } arb_state_t;

endpackage : uci_line_arbiter_pkg

// File: rtl/uci_line_arbiter_rr_picker.sv
// ---------------------------------------------------------------------------
// uci_line_arbiter_rr_picker
//   Purely combinational round-robin pick. The search starts at the index
//   after last_idx and wraps, so the previous owner has the lowest priority.
//
//   Ports:
//     req      [NUM_SRC]  request vector
//     last_idx [IDX_W]    index of the previous line owner
//     winner   [NUM_SRC]  one-hot winner (0 when nothing requests)
//     any_req             at least one request is present
// ---------------------------------------------------------------------------
module uci_line_arbiter_rr_picker #(
    parameter int NUM_SRC = 3,
    parameter int IDX_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [IDX_W-1:0]   last_idx,
    output logic [NUM_SRC-1:0] winner,
    output logic               any_req
);

    logic [IDX_W-1:0] idx;

    // Walk from the farthest offset down to the nearest one; the last hit
    // overwrites earlier ones, so the nearest requester after last_idx wins.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first,
        // so no path leaves it unassigned and no latch is inferred.
        winner = '0;
        idx    = '0;
        for (int off = NUM_SRC; off >= 1; off--) begin
            idx = IDX_W'((int'(last_idx) + off) % NUM_SRC);
            if (req[idx]) begin
                winner      = '0;
                winner[idx] = 1'b1;
            end
        end
    end

    assign any_req = |req;

endmodule : uci_line_arbiter_rr_picker

// File: rtl/uci_line_arbiter.sv
// ---------------------------------------------------------------------------
// uci_line_arbiter
//   Shares one UCI character stream (towards the UART TX) between NUM_SRC
//   text producers. Ownership is granted for a whole line, ending with the
//   NEWLINE byte, so lines from different producers never interleave.
//   The output is a registered valid/ready stage sustaining one char/cycle.
//
//   Optional feature (macro LINE_TIMEOUT_EN): if the owning source leaves
//   src_valid_in low for TIMEOUT_CYCLES cycles while locked, the arbiter
//   terminates the line itself with NEWLINE and pulses timeout_out.
//
//   Ports:
//     clk_in          system clock
//     rst_in          asynchronous, active-low reset
//     src_char_in     per-source character
//     src_valid_in    per-source character valid
//     src_ready_out   per-source accept (transfer when valid && ready)
//     char_out        character to the UART TX
//     char_out_valid  char_out holds a character
//     char_out_ready  UART TX accepts char_out
//     grant_out       one-hot current line owner, 0 when idle
//     busy_out        a line is currently owned
//     timeout_out     one-cycle pulse when a stalled line is force-terminated
// ---------------------------------------------------------------------------
module uci_line_arbiter
    import uci_line_arbiter_pkg::*;
#(
    parameter int NUM_SRC        = 3,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic [NUM_SRC-1:0][7:0] src_char_in,
    input  logic [NUM_SRC-1:0]      src_valid_in,
    output logic [NUM_SRC-1:0]      src_ready_out,
    output logic [7:0]              char_out,
    output logic                    char_out_valid,
    input  logic                    char_out_ready,
    output logic [NUM_SRC-1:0]      grant_out,
    output logic                    busy_out,
    output logic                    timeout_out
);

    localparam int               IDX_W      = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    // Pointing at the last source makes source 0 the first winner.
    localparam logic [IDX_W-1:0] LAST_RESET = IDX_W'(NUM_SRC - 1);

    arb_state_t         state;
    logic [IDX_W-1:0]   owner_idx;
    logic [IDX_W-1:0]   last_idx;
    logic [IDX_W-1:0]   win_idx;
    logic [NUM_SRC-1:0] winner;
    logic               any_req;

    logic               out_free;
    logic               owner_valid;
    logic [7:0]         owner_char;
    logic               stall_hit;
    logic               term_fire;
    logic               xfer;
    logic               load;
    logic [7:0]         load_char;
    logic               line_end;

    uci_line_arbiter_rr_picker #(
        .NUM_SRC (NUM_SRC),
        .IDX_W   (IDX_W)
    ) u_picker (
        .req      (src_valid_in),
        .last_idx (last_idx),
        .winner   (winner),
        .any_req  (any_req)
    );

    always_comb begin
        win_idx = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (winner[i]) begin
                win_idx = IDX_W'(i);
            end
        end
    end

    // The output register can take a new char when it is empty or draining.
    assign out_free    = !char_out_valid || char_out_ready;
    assign owner_valid = src_valid_in[owner_idx];
    assign owner_char  = src_char_in[owner_idx];

`ifdef LINE_TIMEOUT_EN
    localparam int               CNT_W       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] STALL_LIMIT = CNT_W'(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] stall_cnt;

    // Only a silent owner counts; back-pressure with valid high does not.
    // Once the limit is reached the counter parks there until the forced
    // NEWLINE has been loaded.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            stall_cnt <= '0;
        end else if (state == ARB_IDLE || xfer) begin
            stall_cnt <= '0;
        end else if (!owner_valid && !stall_hit) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

    assign stall_hit = (state == ARB_LOCKED) && (stall_cnt == STALL_LIMIT);
    assign term_fire = stall_hit && out_free;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = |TIMEOUT_CYCLES;
    assign stall_hit          = 1'b0;
    assign term_fire          = 1'b0;
`endif

    // Owner's ready is withheld once a forced termination is pending so the
    // source cannot slip a char in alongside the injected NEWLINE.
    always_comb begin
        src_ready_out = '0;
        if (state == ARB_LOCKED && out_free && !stall_hit) begin
            src_ready_out[owner_idx] = 1'b1;
        end
    end

    assign xfer      = (state == ARB_LOCKED) && out_free && !stall_hit && owner_valid;
    assign load      = xfer || term_fire;
    assign load_char = term_fire ? NEWLINE : owner_char;
    assign line_end  = load && (load_char == NEWLINE);

    always_ff @(posedge clk_in or negedge rst_in) begin
        // NOTE: all registers use non-blocking assignments, so every update in
        // this block sees pre-edge values regardless of statement order.
        if (!rst_in) begin
            state          <= ARB_IDLE;
            grant_out      <= '0;
            busy_out       <= 1'b0;
            owner_idx      <= '0;
            last_idx       <= LAST_RESET;
            char_out       <= '0;
            char_out_valid <= 1'b0;
            timeout_out    <= 1'b0;
        end else begin
            timeout_out <= term_fire;

            if (load) begin
                char_out       <= load_char;
                char_out_valid <= 1'b1;
            end else if (char_out_ready) begin
                char_out_valid <= 1'b0;
            end

            // Arbitration in IDLE does not wait for the output register: a
            // NEWLINE still held under back-pressure does not block it.
            case (state)
                ARB_IDLE: begin
                    if (any_req) begin
                        grant_out <= winner;
                        owner_idx <= win_idx;
                        busy_out  <= 1'b1;
                        state     <= ARB_LOCKED;
                    end
                end
                ARB_LOCKED: begin
                    if (line_end) begin
                        grant_out <= '0;
                        busy_out  <= 1'b0;
                        last_idx  <= owner_idx;
                        state     <= ARB_IDLE;
                    end
                end
            endcase
        end
    end

endmodule : uci_line_arbiter
